// File: rtl/dvv_bcast_fifo.sv
// One-producer / CH-subscriber broadcast FIFO over a single shared storage array.
// Define DVV_BCAST_LOSSY_EN to overwrite the oldest entry of a full channel instead of stalling the producer.
module dvv_bcast_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int CH    = 4,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int DCW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  input  logic [CH-1:0]     ch_en,
  output logic [CH-1:0]     m_valid,
  input  logic [CH-1:0]     m_ready,
  output logic [CH*DW-1:0]  m_data,
  output logic [CH*CW-1:0]  ch_cnt,
  output logic [CH*DCW-1:0] drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_next;
  logic [AW-1:0] rd_ptr [CH];
  logic [CW-1:0] cnt [CH];
  logic [CH-1:0] full;
  logic [CH-1:0] pop;
  logic [CH-1:0] ovr;
  logic          wr_en;

  assign wr_en       = s_valid & s_ready;
  assign wr_ptr_next = wr_ptr + AW'(wr_en);

  always_comb begin
    full    = '0;
    pop     = '0;
    m_valid = '0;
    m_data  = '0;
    ch_cnt  = '0;
    for (int c = 0; c < CH; c++) begin
      full[c]              = (cnt[c] == CW'(DEPTH));
      m_valid[c]           = (cnt[c] != '0);
      // A channel being disabled this cycle ignores its m_ready.
      pop[c]               = ch_en[c] & m_valid[c] & m_ready[c];
      m_data[c*DW +: DW]   = mem[rd_ptr[c]];
      ch_cnt[c*CW +: CW]   = cnt[c];
    end
  end

`ifdef DVV_BCAST_LOSSY_EN
  logic [DCW-1:0] drop [CH];

  function automatic logic [DCW-1:0] sat_inc(input logic [DCW-1:0] v);
    return (&v) ? v : v + DCW'(1);
  endfunction

  assign s_ready = 1'b1;

  always_comb begin
    ovr      = '0;
    drop_cnt = '0;
    for (int c = 0; c < CH; c++) begin
      ovr[c]                 = wr_en & ch_en[c] & full[c] & ~pop[c];
      drop_cnt[c*DCW +: DCW] = drop[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) drop[c] <= '0;
    end else begin
      for (int c = 0; c < CH; c++) if (ovr[c]) drop[c] <= sat_inc(drop[c]);
    end
  end
`else
  // Depends only on registered counts and ch_en, never on m_ready.
  assign s_ready  = ~|(full & ch_en);
  assign ovr      = '0;
  assign drop_cnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_ptr <= '0;
    else     wr_ptr <= wr_ptr_next;
  end

  // Disabled channels track the write pointer so re-enabling starts empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (!ch_en[c]) begin
          rd_ptr[c] <= wr_ptr_next;
          cnt[c]    <= '0;
        end else begin
          if (pop[c] || ovr[c]) rd_ptr[c] <= rd_ptr[c] + AW'(1);
          if (wr_en && !pop[c] && !ovr[c]) cnt[c] <= cnt[c] + CW'(1);
          else if (!wr_en && pop[c])       cnt[c] <= cnt[c] - CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_dvv_bcast_fifo.sv
// Randomized scoreboard bench for dvv_bcast_fifo: per-channel expected-item queues checked by a monitor.
module tb_dvv_bcast_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CH    = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int DCW   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DW-1:0]     s_data = '0;
  logic [CH-1:0]     ch_en = '1;
  logic [CH-1:0]     m_valid;
  logic [CH-1:0]     m_ready = '0;
  logic [CH*DW-1:0]  m_data;
  logic [CH*CW-1:0]  ch_cnt;
  logic [CH*DCW-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q [CH][$];
  int unsigned   dexp [CH];

  dvv_bcast_fifo #(.DW(DW), .DEPTH(DEPTH), .CH(CH), .CW(CW), .DCW(DCW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .ch_en(ch_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ch_cnt(ch_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int ch, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: got 0x%0h expected 0x%0h at %0t", name, ch, act, exp, $time);
    end
  endtask

  // Monitor: reads happen before this cycle's edge, so compare against items already in the queues.
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        q[c].delete();
        dexp[c] = 0;
      end
      chk("rst_m_valid", 0, int'(m_valid), 0);
      chk("rst_ch_cnt", 0, int'(ch_cnt), 0);
      chk("rst_s_ready", 0, int'(s_ready), 1);
    end else begin
      bit exp_rdy;
      exp_rdy = 1'b1;
`ifndef DVV_BCAST_LOSSY_EN
      for (int c = 0; c < CH; c++)
        if (ch_en[c] && q[c].size() == DEPTH) exp_rdy = 1'b0;
`endif
      chk("s_ready", 0, int'(s_ready), int'(exp_rdy));
      for (int c = 0; c < CH; c++) begin
        chk("ch_cnt", c, int'(ch_cnt[c*CW +: CW]), q[c].size());
        chk("m_valid", c, int'(m_valid[c]), int'(q[c].size() != 0));
        chk("drop_cnt", c, int'(drop_cnt[c*DCW +: DCW]), int'(dexp[c]));
        if (q[c].size() != 0 && m_valid[c]) begin
          chk("m_data", c, int'(m_data[c*DW +: DW]), int'(q[c][0]));
          if (ch_en[c] && m_ready[c]) void'(q[c].pop_front());
        end
      end
    end
  end

  // Reference model: accepted writes broadcast to every enabled channel.
  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        if (!ch_en[c]) q[c].delete();
        else if (s_valid && s_ready) begin
`ifdef DVV_BCAST_LOSSY_EN
          if (q[c].size() == DEPTH) begin
            void'(q[c].pop_front());
            if (dexp[c] < (1 << DCW) - 1) dexp[c]++;
          end
`endif
          q[c].push_back(s_data);
        end
      end
    end
  end

  task automatic put(input logic [DW-1:0] d);
    int  n;
    bit  acc;
    n   = 0;
    acc = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    while (!acc && n < 100) begin
      #3;
      acc = s_ready;
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL put_timeout: got s_ready=0 for %0d cycles expected acceptance", n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    idle(1);

    // Three items, nobody reading.
    put(8'h11); put(8'h22); put(8'h33);
    idle(2);
    chk("three_cnt", 0, int'(ch_cnt[0 +: CW]), 3);
    m_ready = '1;
    idle(4);

    // One stalled channel back-pressures the producer after DEPTH items.
    m_ready = 4'b1101;
    fork
      for (int i = 0; i < 9; i++) put(DW'(8'h40 + i));
      begin idle(14); m_ready[1] = 1'b1; end
    join
    idle(4);

    // Continuous stream across pointer wrap.
    m_ready = '1;
    for (int i = 0; i < 20; i++) put(DW'(i));
    idle(3);

    // Late enable and disable with pending data.
    ch_en[2] = 1'b0;
    put(8'hA0); put(8'hA1);
    ch_en[2] = 1'b1;
    put(8'hA2);
    m_ready[3] = 1'b0;
    put(8'hB0); put(8'hB1);
    ch_en[3] = 1'b0;
    m_ready[3] = 1'b1;
    idle(2);
    chk("dis_cnt", 3, int'(ch_cnt[3*CW +: CW]), 0);
    ch_en[3] = 1'b1;
    idle(2);

`ifdef DVV_BCAST_LOSSY_EN
    m_ready = 4'b1110;
    for (int i = 0; i < 12; i++) put(DW'(i));
    idle(1);
    chk("lossy_drop", 0, int'(drop_cnt[0 +: DCW]), 4);
    m_ready = '1;
    idle(10);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = DW'($urandom);
      m_ready = CH'($urandom);
      if ($urandom_range(0, 19) == 0) ch_en[$urandom_range(0, CH - 1)] ^= 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    ch_en   = '1;
    m_ready = '1;
    idle(DEPTH + 2);

    // Reset mid-burst.
    m_ready = '0;
    for (int i = 0; i < 5; i++) put(DW'(8'hC0 + i));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    put(8'hEE);
    idle(1);
    chk("post_rst_cnt", 0, int'(ch_cnt[0 +: CW]), 1);
    chk("post_rst_data", 0, int'(m_data[0 +: DW]), 8'hEE);
    m_ready = '1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
